// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a small signed ALU with a
// single result slot and per-requester delivered-result counters.
//
// slot state | meaning
// SLOT_EMPTY | no result held, any valid command may be accepted
// SLOT_FULL  | result held on res_data/res_id, waiting for res_ready
module alu_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [1:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [1:0] req1_op,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [8:0] res_data,
  output logic       res_id,
  output logic [7:0] done_cnt0,
  output logic [7:0] done_cnt1
);

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_e;

  slot_e      slot_q, slot_d;
  logic       rr_q, rr_d;
  logic [8:0] data_q, data_d;
  logic       id_q, id_d;
  logic       slot_free;
  logic       accept;
  logic       grant_id;
  logic       handshake;
  logic [8:0] alu_res;

  // Operands are sign-extended to 9 bits, so a+b and a-b always fit.
  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                      input logic [1:0] op);
    logic [8:0] ax;
    logic [8:0] bx;
    ax = {a[7], a};
    bx = {b[7], b};
    case (op)
      2'b00:   return ax;
      2'b01:   return bx;
      2'b10:   return ax + bx;
      default: return ax - bx;
    endcase
  endfunction

  // Grant decision: ready depends only on valids, rr, slot state and res_ready.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    slot_free  = (slot_q == SLOT_EMPTY) || res_ready;
    if (rst_n && slot_free) begin
      if (req0_valid && req1_valid) begin
        req0_ready = ~rr_q;
        req1_ready = rr_q;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
    accept    = req0_ready | req1_ready;
    grant_id  = req1_ready;
    handshake = (slot_q == SLOT_FULL) && res_ready;
    alu_res   = grant_id ? alu_f(req1_a, req1_b, req1_op)
                         : alu_f(req0_a, req0_b, req0_op);
  end

  // Slot next state: a new accept always (re)loads, otherwise a handshake empties.
  always_comb begin
    slot_d = slot_q;
    rr_d   = rr_q;
    data_d = data_q;
    id_d   = id_q;
    if (accept) begin
      slot_d = SLOT_FULL;
      rr_d   = ~grant_id;
      data_d = alu_res;
      id_d   = grant_id;
    end else if (handshake) begin
      slot_d = SLOT_EMPTY;
    end
  end

  // State registers; reset drops any pending result without counting it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q    <= SLOT_EMPTY;
      rr_q      <= 1'b0;
      data_q    <= 9'd0;
      id_q      <= 1'b0;
      done_cnt0 <= 8'd0;
      done_cnt1 <= 8'd0;
    end else begin
      slot_q <= slot_d;
      rr_q   <= rr_d;
      data_q <= data_d;
      id_q   <= id_d;
      if (handshake) begin
        if (id_q) done_cnt1 <= done_cnt1 + 8'd1;
        else      done_cnt0 <= done_cnt0 + 8'd1;
      end
    end
  end

  assign res_valid = (slot_q == SLOT_FULL);
  assign res_data  = data_q;
  assign res_id    = id_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL use one clock, clk; reset rst_n SHALL be synchronous and active-low.
REQ-002 Ports SHALL be, clock and reset first (name  direction  width  meaning):
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req0_valid  input  1  requester 0 command valid
- req0_ready  output  1  requester 0 command accepted this cycle
- req0_a, req0_b  input  8 each  signed operands, requester 0
- req0_op  input  2  opcode, requester 0
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
- res_valid  output  1  result held and valid
- res_ready  input  1  consumer accepts result
- res_data  output  9  signed result
- res_id  output  1  requester that issued the result
- done_cnt0, done_cnt1  output  8 each  delivered-result counts per requester

Function
REQ-003 Opcodes SHALL be: 00 -> a; 01 -> b; 10 -> a+b; 11 -> a-b; operands sign-extended to 9 bits before arithmetic; no overflow possible.
REQ-004 The block SHALL hold one result slot; a command is accepted only when the slot is empty, or full with res_ready=1 in the same cycle.
REQ-005 At most one command SHALL be accepted per cycle; reqN_ready SHALL be 1 only for the granted requester, and only when reqN_valid=1 and REQ-004 holds.
REQ-006 Arbitration SHALL be round-robin via a 1-bit pointer rr: if both valid, requester rr wins; if only one valid, it wins regardless of rr.
REQ-007 After each accept, rr SHALL become the index of the requester not granted; rr SHALL be unchanged in cycles without an accept.
REQ-008 reqN_ready SHALL be combinational from valids, rr, slot state and res_ready; it SHALL NOT depend on operand or opcode values.
REQ-009 Latency SHALL be one cycle: a command accepted on edge k SHALL appear on res_data/res_id with res_valid=1 after edge k.
REQ-010 While res_valid=1 and res_ready=0, res_data and res_id SHALL remain stable and both reqN_ready SHALL be 0.
REQ-011 On res_valid & res_ready with no accept, res_valid SHALL go 0 on the next edge; with a simultaneous accept, res_valid SHALL stay 1 and the new result SHALL load.
REQ-012 On each res_valid & res_ready handshake, done_cnt[res_id] SHALL increment by 1, wrapping 255 -> 0.
REQ-013 res_data and res_id SHALL retain their last value when res_valid=0.
REQ-014 Commands with valid=1 and ready=0 SHALL NOT be consumed; requesters are responsible for holding them stable.

Reset
REQ-015 While rst_n=0 at a rising edge, on that edge: res_valid=0, res_data=0, res_id=0, done_cnt0=0, done_cnt1=0, rr=0.
REQ-016 While rst_n=0, req0_ready and req1_ready SHALL be 0.
REQ-017 Reset asserted mid-operation SHALL discard a pending result without a handshake and without counting it.

Verification
REQ-018 Reset, res_ready=1; req0 a=127, b=1, op=10 for one cycle -> req0_ready=1; next cycle res_valid=1, res_data=9'h080 (+128), res_id=0; done_cnt0=1 after the handshake.
REQ-019 req1 a=-128, b=127, op=11 -> res_data=9'h101 (-255), res_id=1; op=00 with a=-1 -> res_data=9'h1FF.
REQ-020 Both requesters valid continuously from reset, res_ready=1 -> grants 0,1,0,1 on consecutive cycles; one result per cycle; res_id alternates.
REQ-021 Slot full with res_ready=0 for 5 cycles, both valid -> both ready=0, res_data stable; res_ready=1 -> same-cycle accept of the rr requester, res_valid stays 1.
REQ-022 256 completed handshakes from requester 1 -> done_cnt1=0, done_cnt0 unchanged.
REQ-023 rst_n=0 for one edge with res_valid=1 and res_ready=0 -> res_valid=0, counters=0; next grant with both valid goes to req0.
